bcd_timer_clock: RTL and testbench

- Parametrised successor to the MM:SS digital clock.
- Four BCD digits (min_tens, min_ones, sec_tens, sec_ones), each driving a 7-segment FND output.
- Adds a configurable second prescaler, run/pause, up (stopwatch) and down (countdown) modes, a parallel digit load with clamping, and an expiry flag.
- Sits between the board clock and the four-digit FND display.

---
 rtl/bcd_timer_clock.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_timer_clock.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_clock.sv
// MM:SS BCD timer/clock: prescaled second tick, up/down counting, clamped
// parallel load, sticky countdown-expiry flag and 7-segment digit decode.
module bcd_timer_clock #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned MIN_LIMIT      = 59,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       mode,
    input  logic       load,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    output logic [3:0] out_min_tens,
    output logic [3:0] out_min_ones,
    output logic [3:0] out_sec_tens,
    output logic [3:0] out_sec_ones,
    output logic [6:0] FND3,
    output logic [6:0] FND2,
    output logic [6:0] FND1,
    output logic [6:0] FND0,
    output logic       tick,
    output logic       wrap,
    output logic       done
);

    localparam int unsigned  PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]   LIM_T     = 4'(MIN_LIMIT / 10);
    localparam logic [3:0]   LIM_O     = 4'(MIN_LIMIT % 10);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t        state_q, state_n;
    logic [15:0]   time_q, time_n;   // {min_tens, min_ones, sec_tens, sec_ones}
    logic [PW-1:0] presc_q, presc_n;
    logic          tick_n, wrap_n, done_n;

    logic [15:0]   ld_t, up_t, dn_t;
    logic          up_wrap, dn_zero, time_zero, ld_zero;

    // Per-digit clamp of the load value, then limit the minutes pair.
    always_comb begin
        ld_t[15:12] = (load_min_tens > 4'd9) ? 4'd9 : load_min_tens;
        ld_t[11:8]  = (load_min_ones > 4'd9) ? 4'd9 : load_min_ones;
        ld_t[7:4]   = (load_sec_tens > 4'd5) ? 4'd5 : load_sec_tens;
        ld_t[3:0]   = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;
        // Valid BCD digit pairs compare correctly as plain 8-bit values.
        if (ld_t[15:8] > {LIM_T, LIM_O}) begin
            ld_t[15:8] = {LIM_T, LIM_O};
        end
        ld_zero = (ld_t == 16'd0);
    end

    // Next time value for one up step, with rollover at MIN_LIMIT:59.
    always_comb begin
        up_t    = time_q;
        up_wrap = 1'b0;
        if (time_q[3:0] != 4'd9) begin
            up_t[3:0] = time_q[3:0] + 4'd1;
        end else begin
            up_t[3:0] = 4'd0;
            if (time_q[7:4] != 4'd5) begin
                up_t[7:4] = time_q[7:4] + 4'd1;
            end else begin
                up_t[7:4] = 4'd0;
                if (time_q[15:8] == {LIM_T, LIM_O}) begin
                    up_t[15:8] = 8'd0;
                    up_wrap    = 1'b1;
                end else if (time_q[11:8] == 4'd9) begin
                    up_t[11:8]  = 4'd0;
                    up_t[15:12] = time_q[15:12] + 4'd1;
                end else begin
                    up_t[11:8] = time_q[11:8] + 4'd1;
                end
            end
        end
    end

    // Next time value for one down step; never used from 00:00.
    always_comb begin
        dn_t = time_q;
        if (time_q[3:0] != 4'd0) begin
            dn_t[3:0] = time_q[3:0] - 4'd1;
        end else begin
            dn_t[3:0] = 4'd9;
            if (time_q[7:4] != 4'd0) begin
                dn_t[7:4] = time_q[7:4] - 4'd1;
            end else begin
                dn_t[7:4] = 4'd5;
                if (time_q[11:8] != 4'd0) begin
                    dn_t[11:8] = time_q[11:8] - 4'd1;
                end else begin
                    dn_t[11:8]  = 4'd9;
                    dn_t[15:12] = time_q[15:12] - 4'd1;
                end
            end
        end
        dn_zero   = (dn_t == 16'd0);
        time_zero = (time_q == 16'd0);
    end

    // Next-state and next-register logic: load beats counting.
    always_comb begin
        state_n = state_q;
        time_n  = time_q;
        presc_n = presc_q;
        tick_n  = 1'b0;
        wrap_n  = 1'b0;
        done_n  = done;
        if (load) begin
            time_n  = ld_t;
            presc_n = '0;
            done_n  = 1'b0;
            if (!run)                state_n = IDLE;
            else if (mode && ld_zero) state_n = EXPIRED;
            else                     state_n = RUN;
        end else begin
            case (state_q)
                EXPIRED: begin
                    presc_n = '0;
                    done_n  = 1'b1;
                    if (!mode) begin
                        state_n = IDLE;
                        done_n  = 1'b0;
                    end
                end
                IDLE, RUN: begin
                    if (!run) begin
                        state_n = IDLE;
                    end else if (mode && time_zero) begin
                        state_n = EXPIRED;
                        done_n  = 1'b1;
                        presc_n = '0;
                    end else begin
                        // Resuming counts on the same edge, so a paused
                        // prescaler continues exactly where it stopped.
                        state_n = RUN;
                        if (presc_q == PRESC_MAX) begin
                            presc_n = '0;
                            tick_n  = 1'b1;
                            if (mode) begin
                                time_n = dn_t;
                                if (dn_zero) begin
                                    done_n  = 1'b1;
                                    state_n = EXPIRED;
                                end
                            end else begin
                                time_n = up_t;
                                wrap_n = up_wrap;
                            end
                        end else begin
                            presc_n = presc_q + PW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= 16'd0;
            presc_q <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            time_q  <= time_n;
            presc_q <= presc_n;
            tick    <= tick_n;
            wrap    <= wrap_n;
            done    <= done_n;
        end
    end

    assign out_min_tens = time_q[15:12];
    assign out_min_ones = time_q[11:8];
    assign out_sec_tens = time_q[7:4];
    assign out_sec_ones = time_q[3:0];

    // BCD digit to segments {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign FND3 = SEG_ACTIVE_LOW ? ~seg7(time_q[15:12]) : seg7(time_q[15:12]);
    assign FND2 = SEG_ACTIVE_LOW ? ~seg7(time_q[11:8])  : seg7(time_q[11:8]);
    assign FND1 = SEG_ACTIVE_LOW ? ~seg7(time_q[7:4])   : seg7(time_q[7:4]);
    assign FND0 = SEG_ACTIVE_LOW ? ~seg7(time_q[3:0])   : seg7(time_q[3:0]);

endmodule

// File: tb/tb_bcd_timer_clock.sv
// Bench for bcd_timer_clock: two instances (MIN_LIMIT 59 and 30) against a
// seconds-count reference model, plus directed literal expectations.
module tb_bcd_timer_clock;

    localparam int TD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0] ld_mt = 4'd0, ld_mo = 4'd0, ld_st = 4'd0, ld_so = 4'd0;

    logic [3:0] o_mt [2];
    logic [3:0] o_mo [2];
    logic [3:0] o_st [2];
    logic [3:0] o_so [2];
    logic [6:0] f3 [2];
    logic [6:0] f2 [2];
    logic [6:0] f1 [2];
    logic [6:0] f0 [2];
    logic       o_tick [2];
    logic       o_wrap [2];
    logic       o_done [2];

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: time as a plain count of seconds.
    int m_t [2] = '{0, 0};
    int m_p [2] = '{0, 0};
    bit m_tick [2] = '{0, 0};
    bit m_wrap [2] = '{0, 0};
    bit m_done [2] = '{0, 0};
    bit m_exp  [2] = '{0, 0};

    always #5 clock = ~clock;

    bcd_timer_clock #(.TICK_DIV(TD), .MIN_LIMIT(59), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clock(clock), .reset(reset), .run(run), .mode(mode), .load(load),
        .load_min_tens(ld_mt), .load_min_ones(ld_mo),
        .load_sec_tens(ld_st), .load_sec_ones(ld_so),
        .out_min_tens(o_mt[0]), .out_min_ones(o_mo[0]),
        .out_sec_tens(o_st[0]), .out_sec_ones(o_so[0]),
        .FND3(f3[0]), .FND2(f2[0]), .FND1(f1[0]), .FND0(f0[0]),
        .tick(o_tick[0]), .wrap(o_wrap[0]), .done(o_done[0]));

    bcd_timer_clock #(.TICK_DIV(TD), .MIN_LIMIT(30), .SEG_ACTIVE_LOW(1'b0)) dut30 (
        .clock(clock), .reset(reset), .run(run), .mode(mode), .load(load),
        .load_min_tens(ld_mt), .load_min_ones(ld_mo),
        .load_sec_tens(ld_st), .load_sec_ones(ld_so),
        .out_min_tens(o_mt[1]), .out_min_ones(o_mo[1]),
        .out_sec_tens(o_st[1]), .out_sec_ones(o_so[1]),
        .FND3(f3[1]), .FND2(f2[1]), .FND1(f1[1]), .FND0(f0[1]),
        .tick(o_tick[1]), .wrap(o_wrap[1]), .done(o_done[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: seconds arithmetic, advanced on every rising edge.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int lim, t, p, cmt, cmo, cst, cso, cm;
            bit tk, wr, dn, ex;
            lim = (i == 0) ? 59 : 30;
            t = m_t[i]; p = m_p[i]; dn = m_done[i]; ex = m_exp[i];
            tk = 1'b0; wr = 1'b0;
            if (reset) begin
                t = 0; p = 0; dn = 1'b0; ex = 1'b0;
            end else if (load) begin
                cmt = (ld_mt > 9) ? 9 : int'(ld_mt);
                cmo = (ld_mo > 9) ? 9 : int'(ld_mo);
                cst = (ld_st > 5) ? 5 : int'(ld_st);
                cso = (ld_so > 9) ? 9 : int'(ld_so);
                cm  = cmt * 10 + cmo;
                if (cm > lim) cm = lim;
                t  = cm * 60 + cst * 10 + cso;
                p  = 0;
                dn = 1'b0;
                ex = run && mode && (t == 0);
            end else if (ex) begin
                p = 0;
                if (!mode) begin ex = 1'b0; dn = 1'b0; end
                else dn = 1'b1;
            end else if (run && mode && t == 0) begin
                ex = 1'b1; dn = 1'b1; p = 0;
            end else if (run) begin
                if (p == TD - 1) begin
                    p  = 0;
                    tk = 1'b1;
                    if (mode) begin
                        t = t - 1;
                        if (t == 0) begin dn = 1'b1; ex = 1'b1; end
                    end else begin
                        t  = (t + 1) % ((lim + 1) * 60);
                        wr = (t == 0);
                    end
                end else begin
                    p = p + 1;
                end
            end
            m_t[i] <= t; m_p[i] <= p; m_tick[i] <= tk;
            m_wrap[i] <= wr; m_done[i] <= dn; m_exp[i] <= ex;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int mn, sc;
                mn = m_t[i] / 60;
                sc = m_t[i] % 60;
                check($sformatf("d%0d_min_tens", i), 32'(o_mt[i]), 32'(mn / 10));
                check($sformatf("d%0d_min_ones", i), 32'(o_mo[i]), 32'(mn % 10));
                check($sformatf("d%0d_sec_tens", i), 32'(o_st[i]), 32'(sc / 10));
                check($sformatf("d%0d_sec_ones", i), 32'(o_so[i]), 32'(sc % 10));
                check($sformatf("d%0d_fnd3", i), 32'(f3[i]), 32'(seg_tab[mn / 10]));
                check($sformatf("d%0d_fnd2", i), 32'(f2[i]), 32'(seg_tab[mn % 10]));
                check($sformatf("d%0d_fnd1", i), 32'(f1[i]), 32'(seg_tab[sc / 10]));
                check($sformatf("d%0d_fnd0", i), 32'(f0[i]), 32'(seg_tab[sc % 10]));
                check($sformatf("d%0d_tick", i), 32'(o_tick[i]), 32'(m_tick[i]));
                check($sformatf("d%0d_wrap", i), 32'(o_wrap[i]), 32'(m_wrap[i]));
                check($sformatf("d%0d_done", i), 32'(o_done[i]), 32'(m_done[i]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        ld_mt = a; ld_mo = b; ld_st = c; ld_so = d;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        // Reset held for two edges.
        cyc(2);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_min_tens", 32'(o_mt[0]), 32'd0);
        check("rst_sec_ones", 32'(o_so[0]), 32'd0);
        check("rst_fnd3", 32'(f3[0]), 32'h3F);
        check("rst_fnd0", 32'(f0[0]), 32'h3F);
        check("rst_done", 32'(o_done[0]), 32'd0);

        // Up count through MIN_LIMIT:59 rollover.
        run = 1'b1; mode = 1'b0;
        do_load(4'd5, 4'd9, 4'd5, 4'd8);
        cyc(3);
        check("up_before_tick", 32'(o_so[0]), 32'd8);
        cyc(1);
        check("up_tick", 32'(o_tick[0]), 32'd1);
        check("up_fnd1", 32'(f1[0]), 32'h6D);
        check("up_fnd0", 32'(f0[0]), 32'h6F);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        cyc(1);
        check("glitch_min_tens", 32'(o_mt[0]), 32'd5);
        check("glitch_sec_ones", 32'(o_so[0]), 32'd9);
        cyc(3);
        check("wrap_pulse", 32'(o_wrap[0]), 32'd1);
        check("wrap_min_tens", 32'(o_mt[0]), 32'd0);
        check("wrap_fnd3", 32'(f3[0]), 32'h3F);
        cyc(1);
        check("wrap_one_cycle", 32'(o_wrap[0]), 32'd0);

        // Pause keeps the partial prescaler count.
        do_load(4'd0, 4'd0, 4'd5, 4'd9);
        cyc(4);
        check("carry_min_ones", 32'(o_mo[0]), 32'd1);
        check("carry_sec_tens", 32'(o_st[0]), 32'd0);
        cyc(2);
        run = 1'b0;
        cyc(10);
        check("pause_min_ones", 32'(o_mo[0]), 32'd1);
        check("pause_sec_ones", 32'(o_so[0]), 32'd0);
        run = 1'b1;
        cyc(1);
        check("resume_no_tick", 32'(o_tick[0]), 32'd0);
        cyc(1);
        check("resume_tick", 32'(o_tick[0]), 32'd1);
        check("resume_sec_ones", 32'(o_so[0]), 32'd1);

        // Countdown with borrows, expiry and release.
        mode = 1'b1;
        do_load(4'd0, 4'd1, 4'd0, 4'd1);
        cyc(4);
        check("down_1_00", 32'(o_mo[0]), 32'd1);
        cyc(4);
        check("down_borrow_mo", 32'(o_mo[0]), 32'd0);
        check("down_borrow_st", 32'(o_st[0]), 32'd5);
        check("down_borrow_so", 32'(o_so[0]), 32'd9);
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        cyc(8);
        check("expire_done", 32'(o_done[0]), 32'd1);
        check("expire_sec_ones", 32'(o_so[0]), 32'd0);
        cyc(20);
        check("expired_hold_done", 32'(o_done[0]), 32'd1);
        check("expired_no_tick", 32'(o_tick[0]), 32'd0);
        mode = 1'b0;
        cyc(1);
        check("expired_release", 32'(o_done[0]), 32'd0);

        // Load clamping, including the MIN_LIMIT=30 instance.
        run = 1'b0;
        do_load(4'd7, 4'd12, 4'd9, 4'd15);
        check("clamp_mt", 32'(o_mt[0]), 32'd5);
        check("clamp_mo", 32'(o_mo[0]), 32'd9);
        check("clamp_st", 32'(o_st[0]), 32'd5);
        check("clamp_so", 32'(o_so[0]), 32'd9);
        check("clamp30_mt", 32'(o_mt[1]), 32'd3);
        check("clamp30_mo", 32'(o_mo[1]), 32'd0);
        do_load(4'd4, 4'd0, 4'd0, 4'd0);
        check("lim30_mt", 32'(o_mt[1]), 32'd3);
        check("lim30_mo", 32'(o_mo[1]), 32'd0);
        check("lim59_mt", 32'(o_mt[0]), 32'd4);

        // Load on a tick cycle wins; reset mid-run restarts the prescaler.
        run = 1'b1;
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(3);
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        check("load_tick_mt", 32'(o_mt[0]), 32'd1);
        check("load_tick_so", 32'(o_so[0]), 32'd4);
        check("load_tick_none", 32'(o_tick[0]), 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrun_rst_mt", 32'(o_mt[0]), 32'd0);
        check("midrun_rst_so", 32'(o_so[0]), 32'd0);
        cyc(3);
        check("post_rst_no_tick", 32'(o_tick[0]), 32'd0);
        cyc(1);
        check("post_rst_tick", 32'(o_tick[0]), 32'd1);
        check("post_rst_so", 32'(o_so[0]), 32'd1);

        cyc(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
